// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: DATA_W-bit words in over valid/ready, one bit per cycle out.
// A one-word holding register keeps the serial stream gap-free across back-to-back words.
module piso_serializer #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] parallel_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              serial_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              serial_ready_i,
  output logic              empty_o
);

  localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;

  logic busy;
  logic in_fire;
  logic out_fire;
  logic load;

  assign busy       = (state_q == StShift);
  assign in_ready_o = ~hold_vld_q;
  assign valid_o    = busy;
  assign serial_o   = LSB_FIRST ? shift_q[0] : shift_q[DATA_W-1];
  assign last_o     = busy & (bit_cnt_q == LastCnt);
  assign empty_o    = ~busy & ~hold_vld_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = valid_o & serial_ready_i;
  // Refill on the same edge that consumes the last bit, so back-to-back words have no bubble.
  assign load     = hold_vld_q & (~busy | (out_fire & last_o));

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;

    // Capture needs an empty holder and load needs a full one, so they never collide.
    if (in_fire) begin
      hold_d     = parallel_i;
      hold_vld_d = 1'b1;
    end

    if (load) begin
      shift_d    = hold_q;
      bit_cnt_d  = '0;
      state_d    = StShift;
      hold_vld_d = 1'b0;
    end else if (out_fire) begin
      if (last_o) begin
        state_d   = StIdle;
        shift_d   = '0;
        bit_cnt_d = '0;
      end else begin
        shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed and randomized checks of piso_serializer across four width/bit-order configurations.
module tb_piso_serializer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  par0, par1;
  logic [3:0]  par2;
  logic [12:0] par3;
  logic        iv [4];
  logic        sr [4];
  logic        so [4];
  logic        vo [4];
  logic        lo [4];
  logic        ir [4];
  logic        em [4];

  int n_assert;
  int n_fail;

  piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b1)) u_lsb8 (
    .clk(clk), .reset(rst_n), .parallel_i(par0), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .serial_o(so[0]), .valid_o(vo[0]), .last_o(lo[0]), .serial_ready_i(sr[0]), .empty_o(em[0])
  );
  piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b0)) u_msb8 (
    .clk(clk), .reset(rst_n), .parallel_i(par1), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .serial_o(so[1]), .valid_o(vo[1]), .last_o(lo[1]), .serial_ready_i(sr[1]), .empty_o(em[1])
  );
  piso_serializer #(.DATA_W(4), .LSB_FIRST(1'b1)) u_lsb4 (
    .clk(clk), .reset(rst_n), .parallel_i(par2), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
    .serial_o(so[2]), .valid_o(vo[2]), .last_o(lo[2]), .serial_ready_i(sr[2]), .empty_o(em[2])
  );
  piso_serializer #(.DATA_W(13), .LSB_FIRST(1'b0)) u_msb13 (
    .clk(clk), .reset(rst_n), .parallel_i(par3), .in_valid_i(iv[3]), .in_ready_o(ir[3]),
    .serial_o(so[3]), .valid_o(vo[3]), .last_o(lo[3]), .serial_ready_i(sr[3]), .empty_o(em[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int k);
    case (k)
      2:       return 4;
      3:       return 13;
      default: return 8;
    endcase
  endfunction

  function automatic bit lsbf(input int k);
    return (k == 0) || (k == 2);
  endfunction

  // Bit i of the serial order for word w on configuration k.
  function automatic logic exp_bit(input int k, input logic [63:0] w, input int i);
    return lsbf(k) ? w[i] : w[wid(k) - 1 - i];
  endfunction

  task automatic set_par(input int k, input logic [63:0] w);
    case (k)
      0:       par0 = w[7:0];
      1:       par1 = w[7:0];
      2:       par2 = w[3:0];
      default: par3 = w[12:0];
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fire one word (holder must be free), then confirm nothing is valid before the load edge.
  task automatic send(input int k, input logic [63:0] w, input string tag);
    set_par(k, w);
    iv[k] = 1'b1;
    tick();
    iv[k] = 1'b0;
    chk({tag, "_latency"}, 64'(vo[k]), 64'd0);
    tick();
  endtask

  task automatic expect_word(input int k, input logic [63:0] w, input string tag);
    for (int i = 0; i < wid(k); i++) begin
      chk({tag, "_valid"}, 64'(vo[k]), 64'd1);
      chk({tag, "_bit"}, 64'(so[k]), 64'(exp_bit(k, w, i)));
      chk({tag, "_last"}, 64'(lo[k]), 64'(i == wid(k) - 1));
      tick();
    end
  endtask

  task automatic random_stream(input int k);
    logic [63:0] mask;
    logic [63:0] next_w;
    logic [63:0] exp_q [$];
    logic [63:0] rx_w;
    logic [63:0] exp_w;
    int sent, rx, bcnt, lasts, cyc;
    bit fin, fout, obit, olast;
    mask   = (64'd1 << wid(k)) - 64'd1;
    next_w = {$urandom, $urandom} & mask;
    sent = 0; rx = 0; bcnt = 0; lasts = 0; cyc = 0; rx_w = '0;
    while (rx < 32 && cyc < 4000) begin
      set_par(k, next_w);
      iv[k] = (sent < 32) && ($urandom_range(0, 3) != 0);
      sr[k] = ($urandom_range(0, 3) != 0);
      fin   = iv[k] & ir[k];
      fout  = vo[k] & sr[k];
      obit  = so[k];
      olast = lo[k];
      tick();
      cyc++;
      if (fin) begin
        exp_q.push_back(next_w);
        sent++;
        next_w = {$urandom, $urandom} & mask;
      end
      if (fout) begin
        if (lsbf(k)) rx_w[bcnt] = obit;
        else         rx_w[wid(k) - 1 - bcnt] = obit;
        if (olast) lasts++;
        chk("rand_last_pos", 64'(olast), 64'(bcnt == wid(k) - 1));
        bcnt++;
        if (bcnt == wid(k)) begin
          exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_0000_0000_0000;
          chk("rand_word", rx_w, exp_w);
          rx++;
          bcnt = 0;
          rx_w = '0;
        end
      end
    end
    iv[k] = 1'b0;
    sr[k] = 1'b1;
    chk("rand_words_received", 64'(rx), 64'd32);
    chk("rand_last_count", 64'(lasts), 64'd32);
  endtask

  initial begin
    logic [15:0] b2b;
    int bidx;
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    par0 = '0; par1 = '0; par2 = '0; par3 = '0;
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0;
      sr[k] = 1'b1;
    end
    #13;
    chk("rst_in_ready", 64'(ir[0]), 64'd1);
    chk("rst_valid", 64'(vo[0]), 64'd0);
    chk("rst_serial", 64'(so[0]), 64'd0);
    chk("rst_last", 64'(lo[0]), 64'd0);
    chk("rst_empty", 64'(em[0]), 64'd1);
    chk("rst_empty13", 64'(em[3]), 64'd1);
    #7 rst_n = 1'b1;
    tick();

    // Basic LSB-first.
    send(0, 64'hA5, "lsb_a5");
    expect_word(0, 64'hA5, "lsb_a5");
    chk("lsb_empty_after", 64'(em[0]), 64'd1);
    chk("lsb_valid_after", 64'(vo[0]), 64'd0);
    chk("lsb_serial_idle", 64'(so[0]), 64'd0);

    // MSB-first.
    send(1, 64'hA5, "msb_a5");
    expect_word(1, 64'hA5, "msb_a5");
    send(1, 64'h01, "msb_01");
    expect_word(1, 64'h01, "msb_01");
    chk("msb_empty_after", 64'(em[1]), 64'd1);

    // Back-to-back: in_valid held high, second word accepted while the first shifts.
    b2b = 16'h0FF0;
    set_par(0, 64'hF0);
    iv[0] = 1'b1;
    tick();
    chk("b2b_held_ready", 64'(ir[0]), 64'd0);
    chk("b2b_not_empty", 64'(em[0]), 64'd0);
    set_par(0, 64'h0F);
    tick();
    for (int c = 0; c < 16; c++) begin
      chk("b2b_valid", 64'(vo[0]), 64'd1);
      chk("b2b_bit", 64'(so[0]), 64'(b2b[c]));
      chk("b2b_last", 64'(lo[0]), 64'((c == 7) || (c == 15)));
      if (c == 1) chk("b2b_ready_low", 64'(ir[0]), 64'd0);
      tick();
      if (c == 0) iv[0] = 1'b0;
    end
    chk("b2b_valid_end", 64'(vo[0]), 64'd0);
    chk("b2b_empty_end", 64'(em[0]), 64'd1);

    // Backpressure: 3-cycle stall with bit 2 presented.
    send(0, 64'h3C, "bp_3c");
    bidx = 0;
    for (int c = 0; c < 11; c++) begin
      sr[0] = !((c >= 2) && (c < 5));
      chk("bp_valid", 64'(vo[0]), 64'd1);
      chk("bp_bit", 64'(so[0]), 64'(exp_bit(0, 64'h3C, bidx)));
      chk("bp_last", 64'(lo[0]), 64'(bidx == 7));
      tick();
      if (sr[0]) bidx++;
    end
    sr[0] = 1'b1;
    chk("bp_valid_end", 64'(vo[0]), 64'd0);

    // Reset mid-word with a second word held.
    set_par(0, 64'hFF);
    iv[0] = 1'b1;
    tick();
    set_par(0, 64'h55);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("rmw_bit", 64'(so[0]), 64'd1);
      tick();
      iv[0] = 1'b0;
    end
    chk("rmw_held", 64'(ir[0]), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rmw_valid", 64'(vo[0]), 64'd0);
    chk("rmw_serial", 64'(so[0]), 64'd0);
    chk("rmw_empty", 64'(em[0]), 64'd1);
    chk("rmw_ready", 64'(ir[0]), 64'd1);
    chk("rmw_last", 64'(lo[0]), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("rmw_no_resume", 64'(vo[0]), 64'd0);
    send(0, 64'h81, "rmw_81");
    expect_word(0, 64'h81, "rmw_81");
    chk("rmw_empty_end", 64'(em[0]), 64'd1);

    // Random streams.
    random_stream(2);
    random_stream(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out converter, the next generation of the team's 4-bit parallel_to_serial block. It accepts `DATA_W`-bit words over a valid/ready handshake and emits them one bit per cycle, LSB- or MSB-first. A one-word holding register keeps the serial stream gap-free across back-to-back words, and a downstream ready provides backpressure. It sits between a word-oriented producer and a bit-serial link or shift chain.

## Interface
- `DATA_W`, default 8: word width in bits; legal range 2 to 64.
- `LSB_FIRST`, default 1: 1 sends bit 0 first, 0 sends bit `DATA_W-1` first.

- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `parallel_i`  in  DATA_W  Input word; sampled only on input fire.
- `in_valid_i`  in  1  `parallel_i` holds a valid word.
- `in_ready_o`  out  1  Holding register can accept a word.
- `serial_o`  out  1  Current serial bit.
- `valid_o`  out  1  `serial_o` is a valid bit.
- `last_o`  out  1  Current bit is the final bit of its word.
- `serial_ready_i`  in  1  Downstream accepts the current bit this cycle.
- `empty_o`  out  1  No word is held and no word is in flight.

## Operation
- **State**
  - Holding register `hold_q`/`hold_vld`.
  - Shift register `shift_q`.
  - Bit counter `bit_cnt`, width `$clog2(DATA_W)`.
  - `busy` flag; state SHIFT when `busy=1`, IDLE when `busy=0`.
- **Events**
  - `in_fire = in_valid_i & in_ready_o`.
  - `out_fire = valid_o & serial_ready_i`.
- **Combinational outputs**
  - `in_ready_o = !hold_vld`.
  - `valid_o = busy`.
  - `serial_o = LSB_FIRST ? shift_q[0] : shift_q[DATA_W-1]`.
  - `last_o = busy & (bit_cnt == DATA_W-1)`.
  - `empty_o = !busy & !hold_vld`.
- **Capture:** on `in_fire`, `hold_q <= parallel_i` and `hold_vld <= 1`.
- **Load:** when `hold_vld` and (`!busy` or (`out_fire & last_o`)):
  - `shift_q <= hold_q`, `bit_cnt <= 0`, `busy <= 1`, `hold_vld <= 0`.
  - IDLE→SHIFT, or SHIFT→SHIFT with no bubble.
- **Shift:** on `out_fire & !last_o`:
  - `shift_q` shifts toward the output end (right if `LSB_FIRST`, else left), zero fill.
  - `bit_cnt` increments.
- **Word end:** on `out_fire & last_o` with `!hold_vld`, `busy <= 0` (SHIFT→IDLE). `shift_q` is zeroed, so `serial_o` reads 0 while idle.
- **Stall:** `valid_o & !serial_ready_i` freezes `shift_q`, `bit_cnt` and `serial_o`.
- **No simultaneous capture and load conflict:** capture requires `!hold_vld`, and load requires `hold_vld`.
- **Ignored input:** `in_valid_i` while `in_ready_o=0` is ignored. The producer must hold the word until fire.

## Timing
- **Reset values:** all registers cleared. Outputs: `in_ready_o=1`, `valid_o=0`, `serial_o=0`, `last_o=0`, `empty_o=1`.
- **Latency:** a word fired at edge k is loaded at edge k+1. Its first bit is valid in the cycle after edge k+1.
- **Throughput:** with `serial_ready_i=1`, one word per `DATA_W` cycles, continuous `valid_o`.
  - The second word is accepted one cycle after the first loads.
  - It is loaded on the same edge that consumes the first word's last bit.
- **Word length:** a word occupies exactly `DATA_W` `out_fire` events. `last_o` is asserted on exactly one of them, the final one.
- **Reset mid-word:** asserting `reset` at any time asynchronously discards the in-flight and held words and returns all outputs to their reset values immediately. No partial word is resumed.
- **Backpressure:** stall cycles extend the word without reordering or duplicating bits.

## Test plan
- **Basic LSB-first** (`DATA_W=8`, `LSB_FIRST=1`): fire `8'hA5` with `serial_ready_i=1` → `valid_o` high two cycles later; `serial_o` sequence 1,0,1,0,0,1,0,1; `last_o` only on the 8th bit; then `empty_o=1`, `valid_o=0`.
- **MSB-first** (`LSB_FIRST=0`): fire `8'hA5` → `serial_o` sequence 1,0,1,0,0,1,0,1 (MSB first); fire `8'h01` → 0,0,0,0,0,0,0,1.
- **Back-to-back:** hold `in_valid_i` high with `8'hF0` then `8'h0F` → 16 consecutive `valid_o` cycles with no bubble; `last_o` on cycles 8 and 16; `in_ready_o` low while a word is held.
- **Backpressure:** drop `serial_ready_i` for 3 cycles after bit 2 of `8'h3C` → `serial_o` and `last_o` frozen during the stall; the full bit sequence is unchanged; `valid_o` is high for 11 cycles in total.
- **Reset mid-word:** assert `reset` low after 4 bits of `8'hFF` with a second word held → immediately `valid_o=0`, `serial_o=0`, `empty_o=1`, `in_ready_o=1`; after release, `8'h81` serialises cleanly.
- **Random stream** (`DATA_W=4` and `DATA_W=13`): 32 random words with random `in_valid_i`/`serial_ready_i` → a scoreboard reconstructs every word exactly and in order; `last_o` count equals the word count.
